// File: rtl/axil_pkg.sv
// rtl/axil_pkg.sv - shared response codes, FSM state types and byte-strobe merge for the AXI-Lite register slave
// Purpose: common definitions imported by axil_reg_slave.
//   RESP_OKAY / RESP_SLVERR : 2-bit AXI response codes
//   axil_wr_state_t         : write channel FSM states
//   axil_rd_state_t         : read channel FSM states
//   strb_merge()            : byte-lane merge of new data into an old word
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;

  // Widest data bus the merge helper supports; callers zero-extend/truncate.
  localparam int MAX_DW = 256;
  localparam int MAX_SW = MAX_DW / 8;

  typedef enum logic {W_IDLE, W_RESP} axil_wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} axil_rd_state_t;

  function automatic logic [MAX_DW-1:0] strb_merge(input logic [MAX_DW-1:0] old_v,
                                                   input logic [MAX_DW-1:0] new_v,
                                                   input logic [MAX_SW-1:0] strb);
    logic [MAX_DW-1:0] merged;
    for (int i = 0; i < MAX_SW; i++) begin
      merged[i*8 +: 8] = strb[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/axil_reg_slave.sv
// rtl/axil_reg_slave.sv - AXI4-Lite slave with CTRL/SCRATCH/STATUS/WRCNT registers
// Purpose: four-register AXI4-Lite slave. REG0 CTRL (RW, driven on ctrl_o),
//   REG1 SCRATCH (RW), REG2 STATUS (RO, live status_i), REG3 WRCNT (RO, counts OKAY writes).
// Ports:
//   s_axi_aclk, s_axi_areset       : clock, synchronous active-high reset
//   s_axi_aw*/s_axi_w*/s_axi_b*    : write address, data and response channels
//   s_axi_ar*/s_axi_r*             : read address and data channels
//   ctrl_o                         : current CTRL value
//   status_i                       : live status, returned for REG2 reads
module axil_reg_slave
  import axil_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    RESP_WIDTH = 3,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                    s_axi_aclk,
  input  logic                    s_axi_areset,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [RESP_WIDTH-1:0]   s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [RESP_WIDTH-1:0]   s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [DATA_WIDTH-1:0]   ctrl_o,
  input  logic [DATA_WIDTH-1:0]   status_i
);

  localparam int STRB_W = DATA_WIDTH / 8;

  axil_wr_state_t wr_state_q, wr_state_d;
  axil_rd_state_t rd_state_q, rd_state_d;

  // Halves of a write that arrived before their partner.
  logic                  aw_held_q, w_held_q;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]     w_strb_q;

  logic [DATA_WIDTH-1:0] reg_ctrl_q, reg_scratch_q, reg_wrcnt_q;
  logic [1:0]            bresp_q, rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                  aw_hs, w_hs, ar_hs, commit;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data, wr_old, wr_merged, rd_value;
  logic [STRB_W-1:0]     wr_strb;
  logic                  wr_mapped, rd_mapped;
  logic [1:0]            wr_idx, rd_idx;

  // Window check done one bit wider so BASE_ADDR near the top cannot wrap.
  function automatic logic addr_mapped(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH:0] off;
    off = {1'b0, a} - {1'b0, BASE_ADDR};
    return (a >= BASE_ADDR) && (off < (ADDR_WIDTH+1)'(16));
  endfunction

  function automatic logic [1:0] addr_index(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return off[3:2];
  endfunction

  // Write FSM: next state, ready outputs, commit strobe.
  always_comb begin
    wr_state_d    = wr_state_q;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    commit        = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        s_axi_awready = !aw_held_q && !s_axi_areset;
        s_axi_wready  = !w_held_q && !s_axi_areset;
        if ((aw_held_q || (s_axi_awvalid && s_axi_awready)) &&
            (w_held_q  || (s_axi_wvalid  && s_axi_wready))) begin
          commit     = 1'b1;
          wr_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (s_axi_bready) wr_state_d = W_IDLE;
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs  = s_axi_wvalid && s_axi_wready;

  // A half latched earlier wins over the live bus, which may have moved on.
  assign wr_addr   = aw_held_q ? aw_addr_q : s_axi_awaddr;
  assign wr_data   = w_held_q ? w_data_q : s_axi_wdata;
  assign wr_strb   = w_held_q ? w_strb_q : s_axi_wstrb;
  assign wr_mapped = addr_mapped(wr_addr);
  assign wr_idx    = addr_index(wr_addr);
  assign wr_old    = (wr_idx == 2'd0) ? reg_ctrl_q : reg_scratch_q;
  assign wr_merged = DATA_WIDTH'(strb_merge(MAX_DW'(wr_old), MAX_DW'(wr_data), MAX_SW'(wr_strb)));

  // Read FSM.
  always_comb begin
    rd_state_d    = rd_state_q;
    s_axi_arready = 1'b0;
    case (rd_state_q)
      R_IDLE: begin
        s_axi_arready = !s_axi_areset;
        if (s_axi_arvalid && s_axi_arready) rd_state_d = R_DATA;
      end
      R_DATA: begin
        if (s_axi_rready) rd_state_d = R_IDLE;
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  assign ar_hs     = s_axi_arvalid && s_axi_arready;
  assign rd_mapped = addr_mapped(s_axi_araddr);
  assign rd_idx    = addr_index(s_axi_araddr);

  always_comb begin
    rd_value = '0;
    if (rd_mapped) begin
      case (rd_idx)
        2'd0:    rd_value = reg_ctrl_q;
        2'd1:    rd_value = reg_scratch_q;
        2'd2:    rd_value = status_i;
        default: rd_value = reg_wrcnt_q;
      endcase
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      wr_state_q    <= W_IDLE;
      rd_state_q    <= R_IDLE;
      aw_held_q     <= 1'b0;
      w_held_q      <= 1'b0;
      aw_addr_q     <= '0;
      w_data_q      <= '0;
      w_strb_q      <= '0;
      reg_ctrl_q    <= '0;
      reg_scratch_q <= '0;
      reg_wrcnt_q   <= '0;
      bresp_q       <= RESP_OKAY;
      rresp_q       <= RESP_OKAY;
      rdata_q       <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;

      if (commit) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
        if (wr_mapped && !wr_idx[1]) begin
          if (wr_idx == 2'd0) reg_ctrl_q    <= wr_merged;
          else                reg_scratch_q <= wr_merged;
          reg_wrcnt_q <= reg_wrcnt_q + DATA_WIDTH'(1);
          bresp_q     <= RESP_OKAY;
        end else begin
          bresp_q <= RESP_SLVERR;
        end
      end else begin
        if (aw_hs) begin
          aw_held_q <= 1'b1;
          aw_addr_q <= s_axi_awaddr;
        end
        if (w_hs) begin
          w_held_q <= 1'b1;
          w_data_q <= s_axi_wdata;
          w_strb_q <= s_axi_wstrb;
        end
      end

      // rd_value reads the pre-commit registers, so a same-edge write is not seen.
      if (ar_hs) begin
        rdata_q <= rd_value;
        rresp_q <= rd_mapped ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  assign s_axi_bvalid = (wr_state_q == W_RESP);
  assign s_axi_rvalid = (rd_state_q == R_DATA);
  assign s_axi_bresp  = RESP_WIDTH'(bresp_q);
  assign s_axi_rresp  = RESP_WIDTH'(rresp_q);
  assign s_axi_rdata  = rdata_q;
  assign ctrl_o       = reg_ctrl_q;

endmodule

// File: tb/tb_axil_reg_slave.sv
// tb/tb_axil_reg_slave.sv - self-checking bench for axil_reg_slave
module tb_axil_reg_slave;

  localparam logic [7:0] BASE = 8'h00;

  logic        clk = 1'b0;
  logic        areset;
  logic [7:0]  awaddr, araddr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata, ctrl, status_v;
  logic [3:0]  wstrb;
  logic [2:0]  bresp, rresp;

  always #5 clk = ~clk;

  axil_reg_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .RESP_WIDTH(3), .BASE_ADDR(BASE)) dut (
    .s_axi_aclk(clk), .s_axi_areset(areset),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .ctrl_o(ctrl), .status_i(status_v)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: register contents plus expected response queues.
  logic [31:0] m_ctrl, m_scratch, m_wrcnt;
  logic [2:0]  exp_b[$];
  logic [34:0] exp_r[$];  // {rresp, rdata}

  function automatic void model_reset();
    m_ctrl = 0; m_scratch = 0; m_wrcnt = 0;
    exp_b.delete();
    exp_r.delete();
  endfunction

  function automatic void model_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    int off;
    logic [31:0] v;
    off = int'(a) - int'(BASE);
    if (off >= 0 && off < 8) begin
      v = (off < 4) ? m_ctrl : m_scratch;
      for (int b = 0; b < 4; b++) if (s[b]) v[b*8 +: 8] = d[b*8 +: 8];
      if (off < 4) m_ctrl = v; else m_scratch = v;
      m_wrcnt = m_wrcnt + 1;
      exp_b.push_back(3'd0);
    end else begin
      exp_b.push_back(3'd2);
    end
  endfunction

  function automatic logic [34:0] model_read(input logic [7:0] a);
    int off;
    off = int'(a) - int'(BASE);
    if (off < 0 || off >= 16) return {3'd2, 32'd0};
    if (off < 4)  return {3'd0, m_ctrl};
    if (off < 8)  return {3'd0, m_scratch};
    if (off < 12) return {3'd0, status_v};
    return {3'd0, m_wrcnt};
  endfunction

  // Compare process: responses on handshake, holding under backpressure, no spurious valids.
  bit          prev_bwait, prev_rwait;
  logic [2:0]  prev_bresp;
  logic [34:0] prev_r;
  logic [34:0] er;

  always @(negedge clk) begin
    if (areset) begin
      prev_bwait = 0;
      prev_rwait = 0;
    end else begin
      if (prev_bwait) check("b_hold", {bvalid, bresp}, {1'b1, prev_bresp});
      if (prev_rwait) check("r_hold", {rvalid, rresp, rdata}, {1'b1, prev_r});
      if (bvalid) begin
        check("b_ready_low", {awready, wready}, 2'b00);
        if (exp_b.size() == 0) check("b_spurious", bvalid, 1'b0);
        else if (bready) check("bresp", bresp, exp_b.pop_front());
      end
      if (rvalid) begin
        if (exp_r.size() == 0) check("r_spurious", rvalid, 1'b0);
        else if (rready) begin
          er = exp_r.pop_front();
          check("rresp", rresp, er[34:32]);
          check("rdata", rdata, er[31:0]);
        end
      end
      prev_bwait = bvalid && !bready;
      prev_bresp = bresp;
      prev_rwait = rvalid && !rready;
      prev_r     = {rresp, rdata};
    end
  end

  // All tasks start and end #1 after a rising edge.
  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int w_lead, input bit wait_resp);
    int cyc = 0;
    bit aw_done = 0, w_done = 0, aw_hs, w_hs;
    model_write(a, d, s);
    awaddr = a; wdata = d; wstrb = s;
    while (!(aw_done && w_done) && cyc < 40) begin
      awvalid = !aw_done && (cyc >= (w_lead > 0 ? w_lead : 0));
      wvalid  = !w_done && (cyc >= (w_lead < 0 ? -w_lead : 0));
      @(negedge clk);
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(posedge clk); #1;
      if (aw_hs) aw_done = 1;
      if (w_hs)  w_done = 1;
      cyc++;
    end
    awvalid = 0; wvalid = 0;
    check("write_accepted", {aw_done, w_done}, 2'b11);
    @(negedge clk);
    check("b_latency", bvalid, 1'b1);
    @(posedge clk); #1;
    if (wait_resp) begin
      cyc = 0;
      while (exp_b.size() != 0 && cyc < 20) begin @(posedge clk); #1; cyc++; end
      check("b_drained", exp_b.size(), 0);
    end
  endtask

  task automatic axi_read(input logic [7:0] a, input bit wait_resp,
                          output logic [31:0] d_o, output logic [2:0] r_o);
    int cyc = 0;
    bit hs = 0;
    exp_r.push_back(model_read(a));
    araddr = a;
    while (!hs && cyc < 40) begin
      arvalid = 1;
      @(negedge clk);
      hs = arvalid && arready;
      @(posedge clk); #1;
      cyc++;
    end
    arvalid = 0;
    check("read_accepted", hs, 1'b1);
    @(negedge clk);
    check("r_latency", rvalid, 1'b1);
    d_o = rdata;
    r_o = rresp;
    @(posedge clk); #1;
    if (wait_resp) begin
      cyc = 0;
      while (exp_r.size() != 0 && cyc < 20) begin @(posedge clk); #1; cyc++; end
      check("r_drained", exp_r.size(), 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  logic [31:0] rd;
  logic [2:0]  rr;

  initial begin
    areset = 1; awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
    awaddr = 0; araddr = 0; wdata = 0; wstrb = 0; status_v = 32'hA5A5_0F0F;
    model_reset();

    // 1: reset for two cycles, then release.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {awready, wready, arready}, 3'b000);
    check("rst_valid", {bvalid, rvalid}, 2'b00);
    check("rst_ctrl", ctrl, 32'h0);
    @(posedge clk); #1;
    areset = 0;
    @(negedge clk);
    check("post_rst_ready", {awready, wready, arready}, 3'b111);
    @(posedge clk); #1;

    // 2: AW+W same cycle to CTRL.
    axi_write(BASE + 8'h0, 32'hDEADBEEF, 4'hF, 0, 1);
    check("ctrl_deadbeef", ctrl, 32'hDEADBEEF);
    axi_read(BASE + 8'hC, 1, rd, rr);
    check("wrcnt_1", rd, 32'd1);

    // 3: W three cycles ahead of AW, partial strobes on SCRATCH.
    axi_write(BASE + 8'h4, 32'hFFFFFFFF, 4'hF, 0, 1);
    axi_write(BASE + 8'h4, 32'h12345678, 4'b0101, 3, 1);
    axi_read(BASE + 8'h4, 1, rd, rr);
    check("scratch_merge", rd, 32'hFF34FF78);
    axi_write(BASE + 8'h4, 32'h0000AB00, 4'b0010, -2, 1);  // AW ahead of W
    axi_write(BASE + 8'h4, 32'h0, 4'b0000, 0, 1);          // no lanes, still OKAY
    axi_read(BASE + 8'h4, 1, rd, rr);
    check("scratch_aw_first", rd, 32'hFF34AB78);

    // 4: writes to RO and unmapped addresses, reads of STATUS/WRCNT/unmapped.
    axi_write(BASE + 8'h8, 32'h11111111, 4'hF, 0, 1);
    axi_write(8'h40, 32'h22222222, 4'hF, 1, 1);
    axi_read(BASE + 8'h8, 1, rd, rr);
    check("status_ro", rd, 32'hA5A50F0F);
    axi_read(BASE + 8'hE, 1, rd, rr);  // low address bits ignored
    check("wrcnt_5", rd, 32'd5);
    axi_read(8'h40, 1, rd, rr);
    check("unmapped_rdata", rd, 32'h0);
    check("unmapped_rresp", rr, 3'd2);

    // 5: bready low; a read of WRCNT completes meanwhile.
    bready = 0;
    axi_write(BASE + 8'h0, 32'h00000011, 4'b0001, 0, 0);
    axi_read(BASE + 8'hC, 1, rd, rr);
    check("wrcnt_during_bp", rd, 32'd6);
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_bvalid", {bvalid, awready}, 2'b10);
    @(posedge clk); #1;
    bready = 1;
    repeat (3) @(posedge clk);
    #1;
    check("bp_drained", exp_b.size(), 0);
    check("ctrl_byte0", ctrl, 32'hDEADBE11);

    // 6: reset with a write response and a read response both pending.
    bready = 0; rready = 0;
    axi_write(BASE + 8'h4, 32'h5A5A5A5A, 4'hF, 0, 0);
    axi_read(BASE + 8'h0, 0, rd, rr);
    areset = 1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_valid", {bvalid, rvalid}, 2'b00);
    check("mid_rst_ctrl", ctrl, 32'h0);
    @(posedge clk); #1;
    areset = 0; bready = 1; rready = 1;
    axi_write(BASE + 8'h0, 32'h000000C3, 4'hF, 0, 1);
    check("ctrl_after_rst", ctrl, 32'h000000C3);
    axi_read(BASE + 8'hC, 1, rd, rr);
    check("wrcnt_after_rst", rd, 32'd1);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
